// File: rtl/lm70_pkg.sv
// Shared types and frame-field constants for the LM70 polling controller.
package lm70_pkg;

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, UPDATE, GAP} state_t;

   localparam int TEMP_MSB = 15;
   localparam int TEMP_LSB = 7;
   localparam int TEMP_W   = 9;
   localparam int CMP_W    = 10;

endpackage

// File: rtl/spi_sck_gen.sv
// SCK generator: half-period divider that runs only while 'run' is high.
// Strobes flag the cycle just before the edge where sck rises or falls.
module spi_sck_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic sck,
   output logic rise_stb,
   output logic fall_stb
);

   localparam int DW = $clog2(CLK_DIV) + 1;

   logic [DW-1:0] div_cnt;
   logic          tc;

   assign tc       = (div_cnt == DW'(CLK_DIV - 1));
   assign rise_stb = run & tc & ~sck;
   assign fall_stb = run & tc & sck;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         sck     <= 1'b0;
      end else if (!run) begin
         div_cnt <= '0;
         sck     <= 1'b0;
      end else if (tc) begin
         div_cnt <= '0;
         sck     <= ~sck;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/lm70_poll_ctrl.sv
// Round-robin SPI poller for N_CH LM70-style sensors sharing one SCK, with
// per-channel frame capture and a hysteresis over-temperature alarm.
module lm70_poll_ctrl
   import lm70_pkg::*;
#(
   parameter  int N_CH    = 4,
   parameter  int FRAME_W = 16,
   parameter  int CLK_DIV = 2,
   parameter  int GAP_CYC = 4,
   parameter  int HYST_W  = 4,
   localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      enable,
   input  logic signed [7:0]         temp_set,
   input  logic [HYST_W-1:0]         hyst,
   output logic                      sck,
   output logic [N_CH-1:0]           cs_n,
   input  logic                      sio,
   output logic [N_CH*FRAME_W-1:0]   temp_raw,
   output logic [N_CH-1:0]           temp_vld,
   output logic [N_CH-1:0]           alarm,
   output logic                      frame_done,
   output logic [CH_W-1:0]           done_ch
);

   localparam int BC_W    = $clog2(FRAME_W) + 1;
   localparam int DEG_MSB = (FRAME_W == 16) ? TEMP_MSB : FRAME_W - 1;
   localparam int DEG_LSB = (FRAME_W == 16) ? TEMP_LSB : FRAME_W - TEMP_W;

   state_t             state;
   logic [15:0]        cnt;
   logic [BC_W-1:0]    bit_cnt;
   logic [CH_W-1:0]    ptr;
   logic [CH_W-1:0]    ptr_nx;
   logic [FRAME_W-1:0] sh;
   logic               rise_stb;
   logic               fall_stb;

   // Set at or above temp_set, clear strictly below temp_set - hyst, else hold.
   function automatic logic alarm_next(input logic cur, input logic [FRAME_W-1:0] frame,
                                       input logic signed [7:0] set_in,
                                       input logic [HYST_W-1:0] h);
      logic signed [CMP_W-1:0] deg;
      logic signed [CMP_W-1:0] set_v;
      logic signed [CMP_W-1:0] clr_v;
      logic signed [CMP_W-1:0] h_v;
      deg   = {{(CMP_W-TEMP_W){frame[DEG_MSB]}}, frame[DEG_MSB:DEG_LSB]};
      set_v = {{(CMP_W-8){set_in[7]}}, set_in};
      h_v   = {{(CMP_W-HYST_W){1'b0}}, h};
      clr_v = set_v - h_v;
      if (deg >= set_v)
         alarm_next = 1'b1;
      else if (deg < clr_v)
         alarm_next = 1'b0;
      else
         alarm_next = cur;
   endfunction

   function automatic logic [N_CH-1:0] cs_sel(input logic [CH_W-1:0] p);
      cs_sel    = '1;
      cs_sel[p] = 1'b0;
   endfunction

   assign ptr_nx = (ptr == CH_W'(N_CH - 1)) ? '0 : ptr + 1'b1;

   spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (state == SHIFT),
      .sck      (sck),
      .rise_stb (rise_stb),
      .fall_stb (fall_stb)
   );

   // Shift register is pure datapath; a partial frame is never committed.
   always_ff @(posedge clk) begin
      if (state == SHIFT && rise_stb)
         sh <= {sh[FRAME_W-2:0], sio};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_cnt    <= '0;
         ptr        <= '0;
         cs_n       <= '1;
         temp_raw   <= '0;
         temp_vld   <= '0;
         alarm      <= '0;
         frame_done <= 1'b0;
         done_ch    <= '0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (enable) begin
                  state <= SETUP;
                  cnt   <= '0;
                  cs_n  <= cs_sel(ptr);
               end
            end
            SETUP: begin
               if (cnt == 16'(CLK_DIV - 1)) begin
                  state   <= SHIFT;
                  cnt     <= '0;
                  bit_cnt <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            SHIFT: begin
               if (fall_stb) begin
                  if (bit_cnt == BC_W'(FRAME_W - 1)) begin
                     state <= HOLD;
                     cnt   <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (cnt == 16'(CLK_DIV - 1)) begin
                  state <= UPDATE;
                  cnt   <= '0;
                  cs_n  <= '1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            UPDATE: begin
               temp_raw[ptr*FRAME_W +: FRAME_W] <= sh;
               temp_vld[ptr] <= 1'b1;
               alarm[ptr]    <= alarm_next(alarm[ptr], sh, temp_set, hyst);
               frame_done    <= 1'b1;
               done_ch       <= ptr;
               state         <= GAP;
               cnt           <= '0;
            end
            GAP: begin
               if (cnt == 16'(GAP_CYC - 1)) begin
                  ptr <= ptr_nx;
                  cnt <= '0;
                  if (enable) begin
                     state <= SETUP;
                     cs_n  <= cs_sel(ptr_nx);
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lm70_poll_ctrl.sv
// Directed bench for lm70_poll_ctrl: LM70 sensor models, an SPI protocol
// monitor, and a linear sequence of capture/alarm/enable/reset scenarios.
module tb_lm70_poll_ctrl;

   localparam int N_CH    = 4;
   localparam int FRAME_W = 16;
   localparam int CLK_DIV = 2;
   localparam int GAP_CYC = 4;
   localparam int HYST_W  = 4;
   localparam int FRAME_T = CLK_DIV + 2*FRAME_W*CLK_DIV + CLK_DIV + 1 + GAP_CYC;

   logic                    clk;
   logic                    rst_n;
   logic                    enable;
   logic signed [7:0]       temp_set;
   logic [HYST_W-1:0]       hyst;
   logic                    sck;
   logic [N_CH-1:0]         cs_n;
   logic                    sio;
   logic [N_CH*FRAME_W-1:0] temp_raw;
   logic [N_CH-1:0]         temp_vld;
   logic [N_CH-1:0]         alarm;
   logic                    frame_done;
   logic [1:0]              done_ch;

   logic [15:0] sens [N_CH];
   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   lm70_poll_ctrl #(
      .N_CH(N_CH), .FRAME_W(FRAME_W), .CLK_DIV(CLK_DIV),
      .GAP_CYC(GAP_CYC), .HYST_W(HYST_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .temp_set(temp_set), .hyst(hyst),
      .sck(sck), .cs_n(cs_n), .sio(sio), .temp_raw(temp_raw), .temp_vld(temp_vld),
      .alarm(alarm), .frame_done(frame_done), .done_ch(done_ch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Sensor model: drive the current MSB-first bit, advance after each sck rise.
   int   bitpos = 0;
   int   act    = 0;
   logic prev_sck_m = 1'b0;
   always @(negedge clk) begin
      if (&cs_n) bitpos = 0;
      else if (sck && !prev_sck_m) bitpos++;
      prev_sck_m = sck;
      for (int k = 0; k < N_CH; k++) if (!cs_n[k]) act = k;
      sio = (!(&cs_n) && bitpos < FRAME_W) ? sens[act][FRAME_W-1-bitpos] : 1'b0;
   end

   // Protocol monitor, evaluated at each cs_n window start and end.
   logic [N_CH-1:0] prev_cs = '1;
   logic prev_sck = 1'b0;
   int   rise_cnt = 0;
   int   gap_cnt  = 0;
   bit   gap_skip = 1'b1;
   bit   seen_end = 1'b0;
   bit   oh_bad   = 1'b0;
   bit   sck_out  = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         seen_end = 1'b0; gap_skip = 1'b1; gap_cnt = 0;
         oh_bad = 1'b0; sck_out = 1'b0; rise_cnt = 0;
      end else begin
         if (!(&cs_n) && !$onehot(~cs_n)) oh_bad = 1'b1;
         if ((&cs_n) && sck) sck_out = 1'b1;
         if ((&prev_cs) && !(&cs_n)) begin
            chk("sck_at_cs_fall", sck, 1'b0);
            chk("sck_in_gap", sck_out, 1'b0);
            if (seen_end && !gap_skip) chk("gap_len", gap_cnt, GAP_CYC + 1);
            rise_cnt = 0; gap_skip = 1'b0; sck_out = 1'b0;
         end else if (!(&prev_cs) && (&cs_n)) begin
            chk("sck_at_cs_rise", sck, 1'b0);
            chk("frame_rises", rise_cnt, FRAME_W);
            chk("cs_onehot", oh_bad, 1'b0);
            oh_bad = 1'b0; seen_end = 1'b1; gap_cnt = 1;
            if (!enable) gap_skip = 1'b1;
         end else if (&cs_n) begin
            gap_cnt++;
            if (!enable) gap_skip = 1'b1;
         end
         if (!(&cs_n) && sck && !prev_sck) rise_cnt++;
      end
      prev_cs  = cs_n;
      prev_sck = sck;
   end

   task automatic wait_done(output int ch, output int t);
      ch = -1; t = 0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (frame_done) begin
            ch = int'(done_ch); t = cyc;
            return;
         end
      end
      chk("frame_done_timeout", 0, 1);
   endtask

   task automatic wait_ch(input int ch);
      for (int n = 0; n < 1000; n++) begin
         @(negedge clk);
         if (frame_done && int'(done_ch) == ch) return;
      end
      chk("wait_ch_timeout", 0, 1);
   endtask

   task automatic wait_cs(input logic [N_CH-1:0] pat);
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (cs_n == pat) return;
      end
      chk("wait_cs_timeout", 0, 1);
   endtask

   initial begin
      int ch, t, t_last, low_cyc;
      rst_n = 1'b0; enable = 1'b0; temp_set = 8'sh7F; hyst = '0; sio = 1'b0;
      for (int k = 0; k < N_CH; k++) sens[k] = 16'h0C1F;
      t_last = 0;
      repeat (3) @(negedge clk);
      chk("rst_sck", sck, 1'b0);
      chk("rst_cs_n", cs_n, 4'hF);
      chk("rst_temp_raw", temp_raw, 64'h0);
      chk("rst_temp_vld", temp_vld, 4'h0);
      chk("rst_alarm", alarm, 4'h0);
      chk("rst_frame_done", frame_done, 1'b0);
      chk("rst_done_ch", done_ch, 2'd0);

      // All four channels at 24 C, one frame every FRAME_T cycles.
      rst_n = 1'b1; enable = 1'b1;
      for (int i = 0; i < N_CH; i++) begin
         wait_done(ch, t);
         chk("done_ch_seq", ch, i);
         if (i > 0) chk("frame_interval", t - t_last, FRAME_T);
         t_last = t;
      end
      chk("raw_all_24C", temp_raw, {4{16'h0C1F}});
      chk("vld_all", temp_vld, 4'hF);
      chk("alarm_set_7F", alarm, 4'h0);

      // Hysteresis: set 24, hyst 3; ch0 22 -> 24 -> 22 -> 20.
      temp_set = 8'sd24; hyst = 4'd3;
      sens[0] = 16'h0B1F; wait_ch(0); chk("hyst_22_first", alarm[0], 1'b0);
      sens[0] = 16'h0C1F; wait_ch(0); chk("hyst_24_set", alarm[0], 1'b1);
      sens[0] = 16'h0B1F; wait_ch(0); chk("hyst_22_hold", alarm[0], 1'b1);
      sens[0] = 16'h0A1F; wait_ch(0); chk("hyst_20_clr", alarm[0], 1'b0);

      // Negative temperature and threshold extremes.
      temp_set = -8'sd30; hyst = 4'd0;
      sens[0] = 16'hF380; wait_ch(0);
      chk("neg_raw", temp_raw[15:0], 16'hF380);
      chk("neg_m25_vs_m30", alarm[0], 1'b1);
      temp_set = 8'sh7F;
      sens[0] = 16'h0C1F; wait_ch(0); chk("set_7F_clears", alarm[0], 1'b0);
      temp_set = 8'sd24;
      wait_ch(0); chk("eq_threshold_set", alarm[0], 1'b1);
      sens[0] = 16'h0B9F; wait_ch(0); chk("below_threshold_clr", alarm[0], 1'b0);

      // Drop enable during ch1 SHIFT: frame completes, then idle, resume at ch2.
      sens[1] = 16'h0D1F;
      wait_cs(4'b1101);
      repeat (10) @(negedge clk);
      enable = 1'b0;
      wait_ch(1);
      chk("drop_ch1_raw", temp_raw[31:16], 16'h0D1F);
      low_cyc = 0;
      for (int n = 0; n < 150; n++) begin
         @(negedge clk);
         if (!(&cs_n)) low_cyc++;
      end
      chk("idle_no_cs", low_cyc, 0);
      enable = 1'b1;
      wait_cs(4'b1011);
      chk("resume_ch2", cs_n, 4'b1011);

      // Asynchronous reset mid-SHIFT on ch2.
      repeat (10) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_cs_n", cs_n, 4'hF);
      chk("arst_sck", sck, 1'b0);
      chk("arst_temp_raw", temp_raw, 64'h0);
      chk("arst_temp_vld", temp_vld, 4'h0);
      chk("arst_alarm", alarm, 4'h0);
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      wait_cs(4'b1110);
      chk("restart_ch0", cs_n, 4'b1110);
      wait_ch(0);
      chk("restart_raw0", temp_raw[15:0], 16'h0B9F);
      chk("restart_vld", temp_vld, 4'b0001);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
